x_ctrl: RTL and testbench
=========================

// Module: x_ctrl
// PURPOSE
//  Accumulator-based controller core of the SoC. Fetches one instruction per cycle from program memory,
//  executes it, and masters the shared data bus (regf, prog RAM, debug char-print).
//  Two stages (fetch / execute), no interlocks except a one-bubble branch squash.
// PARAMETERS
//  DATA_W       32  data bus, accumulator RA and pointer RB width
//  ADDR_W       16  data bus address width
//  PROG_ADDR_W  10  program counter width
//  INSTR_W      32  instruction width: [INSTR_W-1 -: 4] opcode, [INSTR_W-5:0] imm (28b)
//  RB_ADDR      16'h0001  data address decoded internally as register RB (never on the bus)
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            asynchronous, active-low reset (0 = reset)
//  pc           out  PROG_ADDR_W  fetch address to program memory
//  instruction  in   INSTR_W      program word for the pc presented in the previous cycle
//  data_sel     out  1            bus access strobe
//  data_we      out  1            1 = write, 0 = read (valid with data_sel)
//  data_addr    out  ADDR_W       bus address
//  data_to_rd   in   DATA_W       read data; combinational, same cycle as data_sel
//  data_to_wr   out  DATA_W       write data (always = RA)
// BEHAVIOUR
//  Reset (rst=0, async): pc=0, RA=0, RB=0, exec-valid=0, so the first post-reset cycle executes NOP.
//   data_sel=0, data_we=0, data_addr=0, data_to_wr=0 during reset.
//  Fetch: every clock, pc<=pc+1 (wraps mod 2^PROG_ADDR_W); exec-valid<=1.
//  Execute acts on the instruction input. Opcodes (M=mem[imm], simm=sign-extended imm):
//   0 NOP; 1 RDW RA=M; 2 WRW M=RA; 3 RDWB RA=mem[RB+imm]; 4 WRWB mem[RB+imm]=RA;
//   5 BEQI if RA==0 pc<=imm; 6 BEQ if RA==0 pc<=M; 7 BNEQI if RA!=0 pc<=imm; 8 BNEQ if RA!=0 pc<=M;
//   9 LDI RA=simm; 10 LDIH RA[31:16]=imm[15:0], RA[15:0] kept; 11 SHFT imm[27]=1 ? RA<<1 : RA>>>1 (arith);
//   12 ADD RA+=M; 13 ADDI RA+=simm; 14 SUB RA-=M; 15 AND RA&=M.
//  Arithmetic is modulo 2^DATA_W; no flags. Branch targets are truncated to PROG_ADDR_W.
//  Bus: data_sel=1 for opcodes 1-4, 6, 8, 12, 14, 15 when exec-valid=1 and the address != RB_ADDR;
//   data_we=1 only for WRW/WRWB. data_addr = imm[ADDR_W-1:0] or (RB+imm) truncated to ADDR_W.
//   data_addr is driven even when data_sel=0. All bus outputs are combinational from the exec stage.
//  RB_ADDR: RDW/ADD/SUB/AND/BEQ/BNEQ read RB; WRW writes RB; no bus cycle. RDWB/WRWB computed
//   address equal to RB_ADDR behaves the same way.
//  Taken branch: pc<=target and exec-valid<=0, so the instruction already fetched is squashed as NOP.
//   A branch in the squashed slot has no effect.
//  exec-valid=0: treat as NOP (no bus strobe, no state change).
//  Mid-operation reset: immediate async clear; a bus write in progress is abandoned.
// STRUCTURE
//  Package xctrldefs: opcode localparams, INSTR_W, opcode/imm field positions, RB_ADDR.
//  Widths ADDR_W, DATA_W and PROG_ADDR_W come from the global defs.
//  One sub-module: x_ctrl_alu (combinational, RA x operand x opcode -> result).
//  Top holds pc, RA, RB, exec-valid, decode and bus muxing.
// TESTING
//  1. Reset: rst=0 then released. pc runs 0,1,2..., with a NOP stream and data_sel never 1.
//  2. LDI -5; ADDI 7; WRW 0x10 -> write strobe at addr 0x10 with data_to_wr=2.
//  3. LDI 0x1234; LDIH 0xABCD; SHFT right -> RA=0xD5E6891A. SHFT left from 0x80000001 -> 0x00000002.
//  4. WRW RB_ADDR with RA=0x20; RDWB 3 -> read at addr 0x23, no strobe when RB is written.
//  5. LDI 0; BEQI 40 -> next pc 40; the instruction after the branch does not execute.
//     BNEQI with RA=0 -> falls through.
//  6. Program looping to pc=2^PROG_ADDR_W-1 wraps to 0.
//     Async reset asserted mid-WRW -> data_sel drops with no clock edge.

Source files
------------

// File: rtl/x_ctrl_pkg.sv
// Shared definitions for the x_ctrl accumulator core:
// widths, opcode encoding, instruction field layout and the RB alias address.
package xctrldefs;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 16;
    localparam int PROG_ADDR_W = 10;
    localparam int INSTR_W     = 32;
    localparam int OP_W        = 4;
    localparam int IMM_W       = INSTR_W - OP_W;

    localparam logic [ADDR_W-1:0] RB_ADDR = 16'h0001;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 4'd0,
        OP_RDW   = 4'd1,
        OP_WRW   = 4'd2,
        OP_RDWB  = 4'd3,
        OP_WRWB  = 4'd4,
        OP_BEQI  = 4'd5,
        OP_BEQ   = 4'd6,
        OP_BNEQI = 4'd7,
        OP_BNEQ  = 4'd8,
        OP_LDI   = 4'd9,
        OP_LDIH  = 4'd10,
        OP_SHFT  = 4'd11,
        OP_ADD   = 4'd12,
        OP_ADDI  = 4'd13,
        OP_SUB   = 4'd14,
        OP_AND   = 4'd15
    } op_e;

    function automatic logic op_uses_bus(op_e op);
        return op inside {OP_RDW, OP_WRW, OP_RDWB, OP_WRWB, OP_BEQ,
                          OP_BNEQ, OP_ADD, OP_SUB, OP_AND};
    endfunction

    function automatic logic op_writes_ra(op_e op);
        return op inside {OP_RDW, OP_RDWB, OP_LDI, OP_LDIH, OP_SHFT,
                          OP_ADD, OP_ADDI, OP_SUB, OP_AND};
    endfunction

endpackage

// File: rtl/x_ctrl_alu.sv
// Combinational accumulator datapath: new RA value from RA,
// the memory operand and the instruction immediate.
module x_ctrl_alu
    import xctrldefs::*;
(
    input  op_e               op_i,
    input  logic [DATA_W-1:0] ra_i,
    input  logic [DATA_W-1:0] m_i,
    input  logic [IMM_W-1:0]  imm_i,
    output logic [DATA_W-1:0] res_o
);

    logic [DATA_W-1:0] simm;
    logic [DATA_W-1:0] sra;
    logic [DATA_W-1:0] shft;

    assign simm = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
    assign sra  = $signed(ra_i) >>> 1;
    assign shft = imm_i[IMM_W-1] ? (ra_i << 1) : sra;

    always_comb begin
        res_o = ra_i;
        unique case (op_i)
            OP_RDW, OP_RDWB: res_o = m_i;
            OP_LDI:          res_o = simm;
            OP_LDIH:         res_o = {imm_i[15:0], ra_i[DATA_W-17:0]};
            OP_SHFT:         res_o = shft;
            OP_ADD:          res_o = ra_i + m_i;
            OP_ADDI:         res_o = ra_i + simm;
            OP_SUB:          res_o = ra_i - m_i;
            OP_AND:          res_o = ra_i & m_i;
            default:         res_o = ra_i;
        endcase
    end

endmodule

// File: rtl/x_ctrl.sv
// Two-stage accumulator controller: fetch counter plus an execute stage
// that decodes the incoming word and masters the shared data bus.
module x_ctrl
    import xctrldefs::*;
(
    input  logic                   clk,
    input  logic                   rst,
    output logic [PROG_ADDR_W-1:0] pc,
    input  logic [INSTR_W-1:0]     instruction,
    output logic                   data_sel,
    output logic                   data_we,
    output logic [ADDR_W-1:0]      data_addr,
    input  logic [DATA_W-1:0]      data_to_rd,
    output logic [DATA_W-1:0]      data_to_wr
);

    logic [PROG_ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0]      ra_q, ra_d;
    logic [DATA_W-1:0]      rb_q, rb_d;
    logic                   ev_q, ev_d;

    op_e                    op;
    logic [IMM_W-1:0]       imm;
    logic                   indexed;
    logic [ADDR_W-1:0]      ea;
    logic                   hit_rb;
    logic [DATA_W-1:0]      m;
    logic [DATA_W-1:0]      alu_res;
    logic                   taken;
    logic                   wr_rb;
    logic                   wr_ra;
    logic [PROG_ADDR_W-1:0] target;

    assign op      = op_e'(instruction[INSTR_W-1 -: OP_W]);
    assign imm     = instruction[IMM_W-1:0];
    assign indexed = (op == OP_RDWB) || (op == OP_WRWB);
    assign ea      = indexed ? rb_q[ADDR_W-1:0] + imm[ADDR_W-1:0]
                             : imm[ADDR_W-1:0];
    // RB is memory-mapped at RB_ADDR and never reaches the bus
    assign hit_rb  = (ea == RB_ADDR);
    assign m       = hit_rb ? rb_q : data_to_rd;

    x_ctrl_alu u_alu (
        .op_i  (op),
        .ra_i  (ra_q),
        .m_i   (m),
        .imm_i (imm),
        .res_o (alu_res)
    );

    always_comb begin
        taken  = 1'b0;
        target = imm[PROG_ADDR_W-1:0];
        unique case (op)
            OP_BEQI:  taken = (ra_q == '0);
            OP_BNEQI: taken = (ra_q != '0);
            OP_BEQ: begin
                taken  = (ra_q == '0);
                target = m[PROG_ADDR_W-1:0];
            end
            OP_BNEQ: begin
                taken  = (ra_q != '0);
                target = m[PROG_ADDR_W-1:0];
            end
            default: taken = 1'b0;
        endcase
    end

    assign wr_rb = ev_q && hit_rb && ((op == OP_WRW) || (op == OP_WRWB));
    assign wr_ra = ev_q && op_writes_ra(op);

    always_comb begin
        pc_d = pc_q + 1'b1;
        ev_d = 1'b1;
        ra_d = ra_q;
        rb_d = rb_q;
        unique case (1'b1)
            !ev_q: ;
            (ev_q && taken): begin
                pc_d = target;
                ev_d = 1'b0;
            end
            wr_rb: rb_d = ra_q;
            wr_ra: ra_d = alu_res;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
            ev_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            ra_q <= ra_d;
            rb_q <= rb_d;
            ev_q <= ev_d;
        end
    end

    assign pc         = pc_q;
    assign data_sel   = rst && ev_q && op_uses_bus(op) && !hit_rb;
    assign data_we    = data_sel && ((op == OP_WRW) || (op == OP_WRWB));
    assign data_addr  = rst ? ea : '0;
    assign data_to_wr = ra_q;

endmodule

// File: tb/tb_x_ctrl.sv
// Scoreboard bench for x_ctrl: an ISA-level interpreter predicts the pc
// trace and bus cycles, a negedge monitor compares them against the core.
module tb_x_ctrl;
    import xctrldefs::*;

    typedef struct {
        int          cyc;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wd;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  pc;
    logic [31:0] instr_r;
    logic        data_sel, data_we;
    logic [15:0] data_addr;
    logic [31:0] data_to_rd, data_to_wr;

    logic [31:0] prog [1024];
    logic [31:0] dmem [65536];
    logic [65535:0] wvalid;
    logic        clr = 1'b1;
    logic [31:0] seed = 32'h1;

    logic [31:0] mm [int];
    ev_t         evq [$];
    logic [9:0]  pcq [$];
    ev_t         mon_e;
    int          mcyc = 0;
    int          mtotal = 0;
    logic        mon_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    x_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .instruction (instr_r),
        .data_sel    (data_sel),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_to_rd  (data_to_rd),
        .data_to_wr  (data_to_wr)
    );

    function automatic logic [31:0] ival(logic [15:0] a, logic [31:0] s);
        return (32'(a) * 32'h9E3779B1) ^ s;
    endfunction

    function automatic logic [31:0] bus_rd(logic [15:0] a);
        return wvalid[a] ? dmem[a] : ival(a, seed);
    endfunction

    function automatic logic [31:0] mk(int op, int imm);
        return {4'(op), 28'(imm)};
    endfunction

    always @(posedge clk) instr_r <= prog[pc];

    assign data_to_rd = wvalid[data_addr] ? dmem[data_addr]
                                          : ival(data_addr, seed);

    always @(posedge clk) begin
        if (clr) begin
            wvalid <= '0;
        end else if (data_sel && data_we) begin
            dmem[data_addr]   <= data_to_wr;
            wvalid[data_addr] <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Instruction-level interpreter: one executed instruction per cycle,
    // one extra idle cycle after every taken branch.
    task automatic model(input int n);
        logic [31:0] ra, rb, ins, simm, m;
        logic [27:0] imm;
        logic [3:0]  op;
        logic [15:0] ea;
        logic [9:0]  tgt;
        logic        taken;
        int          a, c;
        ra = 0; rb = 0; a = 0; c = 1;
        mm.delete();
        pcq.push_back(10'd0);
        for (int k = 0; k < n; k++) begin
            ins  = prog[a];
            op   = ins[31:28];
            imm  = ins[27:0];
            simm = {{4{imm[27]}}, imm};
            pcq.push_back(10'((a + 1) % 1024));
            if (op == 3 || op == 4) ea = 16'(rb + 32'(imm));
            else ea = imm[15:0];
            if (ea == 16'h1) m = rb;
            else if (mm.exists(int'(ea))) m = mm[int'(ea)];
            else m = ival(ea, seed);
            if ((op inside {1, 2, 3, 4, 6, 8, 12, 14, 15}) && ea != 16'h1)
                evq.push_back('{c, (op == 2 || op == 4), ea, ra});
            taken = 0;
            tgt = imm[9:0];
            case (op)
                1, 3: ra = m;
                2, 4: if (ea == 16'h1) rb = ra; else mm[int'(ea)] = ra;
                5: taken = (ra == 0);
                6: begin taken = (ra == 0); tgt = m[9:0]; end
                7: taken = (ra != 0);
                8: begin taken = (ra != 0); tgt = m[9:0]; end
                9: ra = simm;
                10: ra = {imm[15:0], ra[15:0]};
                11: if (imm[27]) ra = ra << 1; else ra = {ra[31], ra[31:1]};
                12: ra = ra + m;
                13: ra = ra + simm;
                14: ra = ra - m;
                15: ra = ra & m;
                default: ;
            endcase
            c++;
            if (taken) begin
                pcq.push_back(tgt);
                a = tgt;
                c++;
            end else begin
                a = (a + 1) % 1024;
            end
        end
        mtotal = c;
    endtask

    always @(negedge clk) begin
        if (mon_en && mcyc < mtotal) begin
            if (pcq.size() == 0) chk("pc queue underrun", 32'(pcq.size()), 1);
            else chk("pc", 32'(pc), 32'(pcq.pop_front()));
            if (data_sel) begin
                if (evq.size() != 0 && evq[0].cyc == mcyc) begin
                    mon_e = evq.pop_front();
                    chk("bus we", 32'(data_we), 32'(mon_e.we));
                    chk("bus addr", 32'(data_addr), 32'(mon_e.addr));
                    if (mon_e.we) chk("bus wdata", data_to_wr, mon_e.wd);
                end else begin
                    chk("unexpected strobe", 32'(data_sel), 0);
                end
            end else if (evq.size() != 0 && evq[0].cyc == mcyc) begin
                chk("missing strobe", 32'(data_sel), 1);
                void'(evq.pop_front());
            end
            mcyc++;
        end
    end

    task automatic run_prog(input int n);
        seed = $urandom;
        evq.delete();
        pcq.delete();
        model(n);
        rst = 1'b0;
        clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset pc", 32'(pc), 0);
        chk("reset sel", 32'(data_sel), 0);
        chk("reset we", 32'(data_we), 0);
        chk("reset addr", 32'(data_addr), 0);
        chk("reset wdata", data_to_wr, 0);
        clr = 1'b0;
        @(posedge clk);
        #1;
        mcyc = 0;
        mon_en = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < mtotal + 5 && mcyc < mtotal; i++) begin
            @(negedge clk);
            #1;
        end
        chk("run completed", 32'(mcyc), 32'(mtotal));
        mon_en = 1'b0;
        chk("pc queue drained", 32'(pcq.size()), 0);
        chk("bus queue drained", 32'(evq.size()), 0);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) prog[i] = 32'h0;
    endtask

    initial begin
        logic found;

        clear_prog();
        run_prog(20);

        clear_prog();
        prog[0]  = mk(9, 28'hFFFFFFB);
        prog[1]  = mk(13, 7);
        prog[2]  = mk(2, 16'h10);
        prog[3]  = mk(9, 16'h1234);
        prog[4]  = mk(10, 16'hABCD);
        prog[5]  = mk(11, 0);
        prog[6]  = mk(2, 16'h11);
        prog[7]  = mk(9, 1);
        prog[8]  = mk(10, 16'h8000);
        prog[9]  = mk(11, 28'h8000000);
        prog[10] = mk(2, 16'h12);
        prog[11] = mk(9, 16'h20);
        prog[12] = mk(2, 1);
        prog[13] = mk(3, 3);
        prog[14] = mk(2, 16'h13);
        prog[15] = mk(9, 0);
        prog[16] = mk(5, 40);
        prog[17] = mk(9, 7);
        prog[40] = mk(2, 16'h14);
        prog[41] = mk(7, 100);
        prog[42] = mk(9, 9);
        prog[43] = mk(2, 16'h15);
        prog[44] = mk(7, 50);
        prog[45] = mk(7, 60);
        prog[50] = mk(2, 16'h16);
        prog[51] = mk(7, 51);
        prog[60] = mk(9, 16'h77);
        prog[61] = mk(2, 16'h16);
        prog[62] = mk(7, 62);
        run_prog(60);
        chk("LDI/ADDI/WRW", bus_rd(16'h10), 32'h2);
        chk("LDIH+SHFT right", bus_rd(16'h11), 32'hD5E6891A);
        chk("SHFT left", bus_rd(16'h12), 32'h2);
        chk("RDWB via RB", bus_rd(16'h13), ival(16'h23, seed));
        chk("RB not on bus", 32'(wvalid[1]), 0);
        chk("BEQI squash", bus_rd(16'h14), 32'h0);
        chk("BNEQI fallthrough", bus_rd(16'h15), 32'h9);
        chk("squashed branch", bus_rd(16'h16), 32'h9);

        clear_prog();
        prog[0] = mk(13, 1);
        prog[1] = mk(2, 16'h10);
        run_prog(2100);
        chk("pc wrap count", bus_rd(16'h10), 32'h3);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 1024; i++) begin
                int op;
                op = $urandom_range(0, 15);
                if (op inside {1, 2, 3, 4, 6, 8, 12, 14, 15})
                    prog[i] = mk(op, $urandom_range(0, 40));
                else
                    prog[i] = mk(op, $urandom);
            end
            run_prog(600);
        end

        clear_prog();
        prog[0] = mk(9, 5);
        prog[1] = mk(2, 16'h10);
        prog[2] = mk(7, 1);
        seed = $urandom;
        rst = 1'b0;
        clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (data_sel && data_we) found = 1'b1;
        end
        chk("midrst write seen", 32'(found), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst sel", 32'(data_sel), 0);
        chk("midrst we", 32'(data_we), 0);
        chk("midrst pc", 32'(pc), 0);
        chk("midrst addr", 32'(data_addr), 0);
        @(posedge clk);
        #1;
        chk("midrst abandoned", bus_rd(16'h10), ival(16'h10, seed));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
